// File: rtl/postcode_ctrl.sv
// postcode_ctrl: bridges a host byte-stream pair to the postcode target interface through two FWFT FIFOs.
// Define POSTCODE_CTRL_STATS_EN to add saturating rx_count / tx_count outputs.

module postcode_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] head,
  output logic       full,
  output logic       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as zero when empty so the outputs are clean out of reset.
  assign head    = empty ? 8'h00 : mem[rd_ptr];

  always_ff @(posedge refclk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end
endmodule

module postcode_ctrl #(
  parameter int DEPTH = 4
) (
  input  logic       refclk,
  input  logic       reset_n,
  input  logic [7:0] host_tx_data,
  input  logic       host_tx_valid,
  output logic       host_tx_ready,
  output logic [7:0] host_rx_data,
  output logic       host_rx_valid,
  input  logic       host_rx_ready,
  input  logic [7:0] pc_rxout,
  input  logic       pc_cs,
  input  logic       pc_last_input,
  input  logic       pc_want_tx,
  input  logic       pc_txstrobe,
  output logic       pc_rxready,
  output logic       pc_tx_pending,
  output logic [7:0] pc_txin,
  output logic       rx_state_dbg,
  output logic [1:0] tx_state_dbg
`ifdef POSTCODE_CTRL_STATS_EN
  ,
  output logic [15:0] rx_count,
  output logic [15:0] tx_count
`endif
);
  // Host streams: a byte moves on any cycle where valid and ready are both high.
  typedef enum logic {R_IDLE = 1'b0, R_ARMED = 1'b1} rx_state_t;
  typedef enum logic [1:0] {T_IDLE = 2'd0, T_OFFER = 2'd1, T_WAIT = 2'd2} tx_state_t;

  rx_state_t  rx_state, rx_state_nx;
  tx_state_t  tx_state, tx_state_nx;

  logic [1:0] cs_sync, last_sync, want_sync, strobe_sync;
  logic       cs_prev, strobe_prev;
  logic [2:0] live;
  logic       cs_rise, strobe_rise;

  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic       tx_pop, rx_push;
  logic [7:0] tx_head;
  logic       rxready_nx, txin_load, offer_second;

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      cs_sync     <= '0;
      last_sync   <= '0;
      want_sync   <= '0;
      strobe_sync <= '0;
      cs_prev     <= 1'b0;
      strobe_prev <= 1'b0;
      live        <= '0;
    end else begin
      cs_sync     <= {cs_sync[0], pc_cs};
      last_sync   <= {last_sync[0], pc_last_input};
      want_sync   <= {want_sync[0], pc_want_tx};
      strobe_sync <= {strobe_sync[0], pc_txstrobe};
      cs_prev     <= cs_sync[1];
      strobe_prev <= strobe_sync[1];
      live        <= {live[1:0], 1'b1};
    end
  end

  // Edges only count once the synchroniser and edge flop hold real samples;
  // otherwise an idle-high pc_cs would look like a rising edge after reset.
  assign cs_rise     = live[2] & cs_sync[1] & ~cs_prev;
  assign strobe_rise = live[2] & strobe_sync[1] & ~strobe_prev;

  postcode_fifo #(.DEPTH(DEPTH)) u_tx_fifo (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .push      (host_tx_valid & host_tx_ready),
    .push_data (host_tx_data),
    .pop       (tx_pop),
    .head      (tx_head),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  postcode_fifo #(.DEPTH(DEPTH)) u_rx_fifo (
    .refclk    (refclk),
    .reset_n   (reset_n),
    .push      (rx_push),
    .push_data (pc_rxout),
    .pop       (host_rx_valid & host_rx_ready),
    .head      (host_rx_data),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  assign host_tx_ready = live[0] & ~tx_full;
  assign host_rx_valid = ~rx_empty;

  always_comb begin
    rx_state_nx = rx_state;
    rxready_nx  = 1'b0;
    rx_push     = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (!rx_full) begin
          rxready_nx  = 1'b1;
          rx_state_nx = R_ARMED;
        end
      end
      R_ARMED: begin
        if (cs_rise && !last_sync[1]) begin
          rx_push     = 1'b1;
          rx_state_nx = R_IDLE;
        end
      end
      default: rx_state_nx = R_IDLE;
    endcase
  end

  always_comb begin
    tx_state_nx = tx_state;
    tx_pop      = 1'b0;
    txin_load   = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (want_sync[1] && !tx_empty) begin
          txin_load   = 1'b1;
          tx_state_nx = T_OFFER;
        end
      end
      T_OFFER: begin
        if (offer_second) tx_state_nx = T_WAIT;
      end
      T_WAIT: begin
        if (strobe_rise) begin
          tx_pop      = 1'b1;
          tx_state_nx = T_IDLE;
        end
      end
      default: tx_state_nx = T_IDLE;
    endcase
  end

  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_state     <= R_IDLE;
      tx_state     <= T_IDLE;
      pc_rxready   <= 1'b0;
      offer_second <= 1'b0;
      pc_txin      <= 8'h00;
    end else begin
      rx_state     <= rx_state_nx;
      tx_state     <= tx_state_nx;
      pc_rxready   <= rxready_nx;
      offer_second <= (tx_state == T_OFFER) && !offer_second;
      if (txin_load) pc_txin <= tx_head;
    end
  end

  assign pc_tx_pending = (tx_state == T_OFFER);
  assign rx_state_dbg  = rx_state;
  assign tx_state_dbg  = tx_state;

`ifdef POSTCODE_CTRL_STATS_EN
  always_ff @(posedge refclk or negedge reset_n) begin
    if (!reset_n) begin
      rx_count <= 16'h0000;
      tx_count <= 16'h0000;
    end else begin
      if (rx_push && rx_count != 16'hFFFF) rx_count <= rx_count + 16'd1;
      if (tx_pop && tx_count != 16'hFFFF)  tx_count <= tx_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_postcode_ctrl.sv
// Self-checking bench for postcode_ctrl: directed scenarios plus random traffic against queue-based models.
module tb_postcode_ctrl;
  localparam int DEPTH = 4;

  logic       refclk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] host_tx_data = 8'h00;
  logic       host_tx_valid = 1'b0;
  logic       host_tx_ready;
  logic [7:0] host_rx_data;
  logic       host_rx_valid;
  logic       host_rx_ready = 1'b0;
  logic [7:0] pc_rxout = 8'h00;
  logic       pc_cs = 1'b1;
  logic       pc_last_input = 1'b0;
  logic       pc_want_tx = 1'b0;
  logic       pc_txstrobe = 1'b0;
  logic       pc_rxready;
  logic       pc_tx_pending;
  logic [7:0] pc_txin;
  logic       rx_state_dbg;
  logic [1:0] tx_state_dbg;
`ifdef POSTCODE_CTRL_STATS_EN
  logic [15:0] rx_count;
  logic [15:0] tx_count;
  int          rx_cnt_exp = 0;
  int          tx_cnt_exp = 0;
`endif

  // clock / reset
  always #5 refclk = ~refclk;

  postcode_ctrl #(.DEPTH(DEPTH)) dut (
    .refclk        (refclk),
    .reset_n       (reset_n),
    .host_tx_data  (host_tx_data),
    .host_tx_valid (host_tx_valid),
    .host_tx_ready (host_tx_ready),
    .host_rx_data  (host_rx_data),
    .host_rx_valid (host_rx_valid),
    .host_rx_ready (host_rx_ready),
    .pc_rxout      (pc_rxout),
    .pc_cs         (pc_cs),
    .pc_last_input (pc_last_input),
    .pc_want_tx    (pc_want_tx),
    .pc_txstrobe   (pc_txstrobe),
    .pc_rxready    (pc_rxready),
    .pc_tx_pending (pc_tx_pending),
    .pc_txin       (pc_txin),
    .rx_state_dbg  (rx_state_dbg),
    .tx_state_dbg  (tx_state_dbg)
`ifdef POSTCODE_CTRL_STATS_EN
    ,
    .rx_count      (rx_count),
    .tx_count      (tx_count)
`endif
  );

  // scoreboard: expected FIFO contents
  int         n_checks = 0;
  int         n_fail = 0;
  logic [7:0] tx_exp_q[$];
  logic [7:0] rx_exp_q[$];
  int         rx_pulses = 0;
  int         pend_rises = 0;
  int         consumed = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  // pulse monitor: rxready must be 1 cycle wide, tx_pending 2 cycles wide
  logic rxr_q = 1'b0;
  logic pend_q = 1'b0;
  int   rxr_run = 0;
  int   pend_run = 0;
  always @(negedge refclk) begin
    if (pc_rxready && !rxr_q) rx_pulses++;
    if (pc_tx_pending && !pend_q) pend_rises++;
    if (pc_rxready) rxr_run++;
    else if (rxr_q) begin
      if (reset_n) check("rxready_width", rxr_run, 1);
      rxr_run = 0;
    end
    if (pc_tx_pending) pend_run++;
    else if (pend_q) begin
      if (reset_n) check("tx_pending_width", pend_run, 2);
      pend_run = 0;
    end
    rxr_q  = pc_rxready;
    pend_q = pc_tx_pending;
  end

  // driver tasks (all start and end on a falling edge)
  task automatic wait_pulse(input string tag);
    int n = 0;
    while (rx_pulses <= consumed && n < 8) begin
      tick(1);
      n++;
    end
    check(tag, rx_pulses > consumed, 1);
  endtask

  task automatic host_write(input logic [7:0] b, input string tag);
    check({tag, "_ready"}, host_tx_ready, tx_exp_q.size() < DEPTH);
    host_tx_data  = b;
    host_tx_valid = 1'b1;
    if (tx_exp_q.size() < DEPTH) tx_exp_q.push_back(b);
    tick(1);
    host_tx_valid = 1'b0;
  endtask

  task automatic host_read(input string tag);
    int n = 0;
    while (!host_rx_valid && n < 8) begin
      tick(1);
      n++;
    end
    check({tag, "_valid"}, host_rx_valid, 1);
    check({tag, "_data"}, host_rx_data, rx_exp_q.size() ? rx_exp_q[0] : 8'h00);
    if (rx_exp_q.size()) void'(rx_exp_q.pop_front());
    host_rx_ready = 1'b1;
    tick(1);
    host_rx_ready = 1'b0;
  endtask

  task automatic target_send(input logic [7:0] b, input logic last);
    if (!last) begin
      wait_pulse("rx_armed");
      consumed++;
    end
    pc_rxout      = b;
    pc_last_input = last;
    pc_cs         = 1'b0;
    tick(3);
    pc_cs = 1'b1;
    tick(4);
    if (!last) begin
      rx_exp_q.push_back(b);
`ifdef POSTCODE_CTRL_STATS_EN
      rx_cnt_exp++;
`endif
    end
  endtask

  // Target side of one TX transfer; want is dropped mid-offer, which must not abort it.
  task automatic target_tx(input string tag);
    int         n = 0;
    int         pr0;
    logic [7:0] exp_b;
    exp_b = tx_exp_q.size() ? tx_exp_q[0] : 8'h00;
    pc_want_tx = 1'b1;
    while (!pc_tx_pending && n < 10) begin
      tick(1);
      n++;
    end
    check({tag, "_offer"}, pc_tx_pending, 1);
    check({tag, "_txin"}, pc_txin, exp_b);
    pc_want_tx = 1'b0;
    n = 0;
    while (pc_tx_pending && n < 5) begin
      tick(1);
      n++;
    end
    check({tag, "_offer_end"}, pc_tx_pending, 0);
    pr0 = pend_rises;
    tick(3);
    check({tag, "_hold"}, pc_txin, exp_b);
    check({tag, "_no_repulse"}, pend_rises, pr0);
    pc_txstrobe = 1'b1;
    tick(2);
    pc_txstrobe = 1'b0;
    tick(2);
    if (tx_exp_q.size()) void'(tx_exp_q.pop_front());
`ifdef POSTCODE_CTRL_STATS_EN
    tx_cnt_exp++;
`endif
  endtask

  initial begin
    int n;
    int pr0;

    // reset state
    tick(3);
    check("rst_rxready", pc_rxready, 0);
    check("rst_tx_pending", pc_tx_pending, 0);
    check("rst_txin", pc_txin, 0);
    check("rst_rx_valid", host_rx_valid, 0);
    check("rst_rx_data", host_rx_data, 0);
    check("rst_tx_ready", host_tx_ready, 0);
    reset_n = 1'b1;
    tick(10);
    check("boot_pulses", rx_pulses, 1);
    check("boot_tx_ready", host_tx_ready, 1);
    check("boot_rx_valid", host_rx_valid, 0);

    // single RX byte
    target_send(8'hA5, 1'b0);
    check("rx_a5_valid", host_rx_valid, 1);
    check("rx_a5_data", host_rx_data, 8'hA5);
    wait_pulse("rx_a5_rearm");
    host_read("rx_a5");

    // cs edge on an input transaction is ignored
    target_send(8'h42, 1'b1);
    check("rx_last_ignored", host_rx_valid, 0);

    // single TX byte with latency check
    pc_want_tx = 1'b1;
    tick(4);
    host_write(8'h3C, "tx3c");
    n = 0;
    while (!pc_tx_pending && n < 8) begin
      tick(1);
      n++;
    end
    check("tx_latency", (n <= 4) && pc_tx_pending, 1);
    target_tx("tx3c");
    pr0 = pend_rises;
    pc_want_tx = 1'b1;
    tick(8);
    check("tx_fifo_empty", pend_rises, pr0);
    pc_want_tx = 1'b0;
    tick(3);

    // TX overfill: fifth write refused, four sent in order
    for (int i = 0; i < 5; i++) host_write(8'($urandom_range(0, 255)), "fill");
    check("fill_ready_low", host_tx_ready, 0);
    for (int i = 0; i < 4; i++) target_tx("drain");
    check("drain_ready", host_tx_ready, 1);

    // RX full: no fifth rxready until a pop
    for (int i = 0; i < 4; i++) target_send(8'($urandom_range(0, 255)), 1'b0);
    tick(15);
    check("rx_full_no_pulse", rx_pulses - consumed, 0);
    host_read("rx_full");
    wait_pulse("rx_full_rearm");
    while (rx_exp_q.size()) host_read("rx_full_rest");

    // random traffic
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 3))
        0: host_write(8'($urandom_range(0, 255)), "rnd_wr");
        1: if (rx_exp_q.size() < DEPTH)
             target_send(8'($urandom_range(0, 255)), $urandom_range(0, 3) == 0);
           else tick(1);
        2: if (rx_exp_q.size()) host_read("rnd_rd");
           else begin
             check("rnd_rx_empty", host_rx_valid, 0);
             tick(1);
           end
        default: if (tx_exp_q.size()) target_tx("rnd_tx");
                 else tick(1);
      endcase
    end
    while (rx_exp_q.size()) host_read("rnd_rx_drain");
    while (tx_exp_q.size()) target_tx("rnd_tx_drain");
`ifdef POSTCODE_CTRL_STATS_EN
    check("stats_rx", rx_count, rx_cnt_exp);
    check("stats_tx", tx_count, tx_cnt_exp);
`endif

    // reset while the TX FSM waits for the strobe
    host_write(8'h77, "rst_mid");
    target_send(8'h11, 1'b0);
    pc_want_tx = 1'b1;
    n = 0;
    while (!pc_tx_pending && n < 10) begin
      tick(1);
      n++;
    end
    check("rst_mid_offer", pc_tx_pending, 1);
    pc_want_tx = 1'b0;
    tick(4);
    reset_n = 1'b0;
    tick(2);
    check("rst_mid_txin", pc_txin, 0);
    check("rst_mid_rx_valid", host_rx_valid, 0);
    check("rst_mid_tx_ready", host_tx_ready, 0);
    check("rst_mid_pending", pc_tx_pending, 0);
`ifdef POSTCODE_CTRL_STATS_EN
    check("rst_mid_rx_count", rx_count, 0);
    check("rst_mid_tx_count", tx_count, 0);
    rx_cnt_exp = 0;
    tx_cnt_exp = 0;
`endif
    tx_exp_q.delete();
    rx_exp_q.delete();
    consumed = rx_pulses;
    reset_n = 1'b1;
    tick(2);
    check("rst_rearm_2cyc", rx_pulses > consumed, 1);
    pr0 = pend_rises;
    pc_want_tx = 1'b1;
    tick(8);
    check("rst_tx_discarded", pend_rises, pr0);
    check("rst_rx_discarded", host_rx_valid, 0);
    pc_want_tx = 1'b0;
    tick(3);

    // function intact after reset
    target_send(8'h5A, 1'b0);
    host_read("post_rst_rx");
    host_write(8'hC3, "post_rst_tx");
    target_tx("post_rst_tx");
`ifdef POSTCODE_CTRL_STATS_EN
    check("post_rst_rx_count", rx_count, rx_cnt_exp);
    check("post_rst_tx_count", tx_count, tx_cnt_exp);
`endif
    tick(2);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
